display_timing_ctrl: RTL and testbench
======================================

// Module: display_timing_ctrl
// PURPOSE
// Configuration and sequencing controller for the display timing driver. Holds a software-visible
// shadow copy of the H/V timing set and commits it atomically to the driver. Commits happen at a
// frame boundary when running, or on enable when stopped. Also generates the driver pixel-tick
// enable (clock divider) and sequences the driver enable/reset. Sits between the CPU register bus
// and the timing driver.
// PARAMETERS
// HCounterWidth  12  width of horizontal timing values and the hcounter input
// VCounterWidth  12  width of vertical timing values and the vcounter input
// ClkDivWidth    4   width of the pixel-tick divisor field
// PORTS
// clk_i          in   1    single clock, rising edge
// rst_i          in   1    asynchronous reset, active-high
// req_i          in   1    bus request, single-cycle
// we_i           in   1    1 = write, 0 = read
// addr_i         in   4    word address
// wdata_i        in   32   write data
// rvalid_o       out  1    response valid, exactly 1 cycle after every req_i
// rdata_o        out  32   read data (0 for writes and unmapped addresses)
// hcounter_i     in   HCW  driver horizontal counter
// vcounter_i     in   VCW  driver vertical counter
// driver_en_o    out  1    driver clock enable
// driver_rst_o   out  1    driver synchronous reset
// h{sync,start,end,total}_o  out  HCW  active horizontal timing to driver
// v{sync,start,end,total}_o  out  VCW  active vertical timing to driver
// frame_start_o  out  1    1-cycle pulse on every frame boundary tick while RUN
// BEHAVIOUR
// Clock/reset: one clock; reset is asynchronous and active-high.
// Reset values: all registers (shadow + active) 0; state OFF; driver_rst_o=1, driver_en_o=1;
//   rvalid_o=0, rdata_o=0, frame_start_o=0.
// Register map:
//   0x0 CTRL    [0] enable; [1] commit (write-1 pulse, reads 0); [11:8] div
//   0x1-0x4     shadow HSYNC, HSTART, HEND, HTOTAL (low HCW bits)
//   0x5-0x8     shadow VSYNC, VSTART, VEND, VTOTAL (low VCW bits)
//   0x9 STATUS  [1:0] state; [2] commit_pending; [3] cfg_err (sticky, cleared by write-1); [31:16] frame_cnt
//   Unmapped: writes ignored, reads 0.
//   Write data lands in registers at the clock edge of the req; reads return the current value.
// Pixel tick: a divider counts 0..div and emits tick when count==div, so the period is div+1 cycles.
//   div=0 gives tick every cycle. The divider is held at 0 outside RUN.
// FSM (STATUS[1:0]): OFF=0, LOAD=1, RUN=2.
//   OFF: driver_rst_o=1, driver_en_o=1, so the driver is held cleared.
//     - Commit write in OFF: active<=shadow on the next edge; pending stays 0.
//     - enable=1 with shadow htotal!=0 and vtotal!=0: go to LOAD.
//     - enable=1 with htotal==0 or vtotal==0: set cfg_err, clear CTRL.enable, stay OFF.
//   LOAD (1 cycle): active<=shadow; driver_rst_o=1, driver_en_o=1; pending<=0; then RUN.
//   RUN: driver_rst_o=0, driver_en_o=tick.
//     - A commit write sets pending. Frame boundary = tick & hcounter_i==htotal_o-1
//       & vcounter_i==vtotal_o-1.
//     - At a boundary: frame_start_o=1 the same cycle and frame_cnt+=1 (wraps at 0xFFFF).
//       If pending, active<=shadow at that edge and pending<=0, so the driver wraps to 0,0
//       on the same edge.
//     - If pending and shadow htotal==0 or vtotal==0 at the boundary: no commit, pending
//       cleared, cfg_err set.
//     - enable=0 written: go to OFF next edge; the driver is reset immediately; pending discarded.
// Simultaneous events:
//   - Commit write on a boundary cycle is not applied at that boundary; it sets pending
//     for the next boundary.
//   - Enable clear + commit in one write: OFF wins, and the commit applies as in OFF.
//   - Shadow writes while pending modify what is committed; the last value before the
//     boundary wins.
// Reset mid-frame returns all state to the reset values asynchronously; no frame_start_o pulse.
// TESTING
// 1. Write H=(96,144,784,800), V=(2,35,515,525), div=1, enable
//    -> LOAD for 1 cycle, then RUN; driver_en_o toggles every 2 cycles; outputs match the shadow.
// 2. RUN, write HTOTAL=900 + commit mid-frame -> htotal_o stays 800 until the boundary tick
//    (h=799, v=524), then 900 on the same edge as frame_start_o; pending 1->0.
// 3. Enable with VTOTAL=0 -> cfg_err=1, state stays OFF, enable reads 0;
//    write-1 to STATUS[3] -> cfg_err=0.
// 4. Commit write on the exact boundary cycle -> not applied there; applied at the
//    following boundary.
// 5. Disable mid-frame -> next edge state=OFF, driver_rst_o=1, driver_en_o=1;
//    frame_cnt holds; pending=0.
// 6. Assert rst_i mid-RUN asynchronously -> all outputs at reset values before the next
//    edge; read of 0xA -> rvalid_o=1, rdata_o=0.

Source files
------------

// File: rtl/display_timing_ctrl.sv
// Display timing configuration controller: shadow/active H/V timing set with frame-synchronous
// commit, pixel-tick divider and driver enable/reset sequencing behind a simple register bus.
module display_timing_ctrl #(
  parameter int unsigned HCounterWidth = 12,
  parameter int unsigned VCounterWidth = 12,
  parameter int unsigned ClkDivWidth   = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_i,
  input  logic                     we_i,
  input  logic [3:0]               addr_i,
  input  logic [31:0]              wdata_i,
  output logic                     rvalid_o,
  output logic [31:0]              rdata_o,
  input  logic [HCounterWidth-1:0] hcounter_i,
  input  logic [VCounterWidth-1:0] vcounter_i,
  output logic                     driver_en_o,
  output logic                     driver_rst_o,
  output logic [HCounterWidth-1:0] hsync_o,
  output logic [HCounterWidth-1:0] hstart_o,
  output logic [HCounterWidth-1:0] hend_o,
  output logic [HCounterWidth-1:0] htotal_o,
  output logic [VCounterWidth-1:0] vsync_o,
  output logic [VCounterWidth-1:0] vstart_o,
  output logic [VCounterWidth-1:0] vend_o,
  output logic [VCounterWidth-1:0] vtotal_o,
  output logic                     frame_start_o
);

  localparam logic [3:0] AddrCtrl   = 4'h0;
  localparam logic [3:0] AddrHsync  = 4'h1;
  localparam logic [3:0] AddrHstart = 4'h2;
  localparam logic [3:0] AddrHend   = 4'h3;
  localparam logic [3:0] AddrHtotal = 4'h4;
  localparam logic [3:0] AddrVsync  = 4'h5;
  localparam logic [3:0] AddrVstart = 4'h6;
  localparam logic [3:0] AddrVend   = 4'h7;
  localparam logic [3:0] AddrVtotal = 4'h8;
  localparam logic [3:0] AddrStatus = 4'h9;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic                     r_enable, r_pending, r_cfg_err, r_rvalid;
  logic [ClkDivWidth-1:0]   r_div, r_div_cnt;
  logic [15:0]              r_frame_cnt;
  logic [31:0]              r_rdata, w_rdata;
  logic [HCounterWidth-1:0] r_sh_hsync, r_sh_hstart, r_sh_hend, r_sh_htotal;
  logic [VCounterWidth-1:0] r_sh_vsync, r_sh_vstart, r_sh_vend, r_sh_vtotal;
  logic [HCounterWidth-1:0] r_hsync, r_hstart, r_hend, r_htotal;
  logic [VCounterWidth-1:0] r_vsync, r_vstart, r_vend, r_vtotal;

  logic w_wr, w_ctrl_wr, w_commit_wr, w_en_wr, w_sh_ok, w_tick, w_boundary;
  logic w_load, w_set_err, w_clr_en, w_pending_nxt;
  logic w_unused_wdata;

  assign w_wr        = req_i & we_i;
  assign w_ctrl_wr   = w_wr & (addr_i == AddrCtrl);
  assign w_commit_wr = w_ctrl_wr & wdata_i[1];
  // Enable value as it will stand after this edge; FSM reacts to the write itself.
  assign w_en_wr     = w_ctrl_wr ? wdata_i[0] : r_enable;
  assign w_sh_ok     = (r_sh_htotal != '0) && (r_sh_vtotal != '0);
  assign w_tick      = (r_state == ST_RUN) && (r_div_cnt == r_div);
  assign w_boundary  = w_tick
                    && (hcounter_i == (r_htotal - HCounterWidth'(1)))
                    && (vcounter_i == (r_vtotal - VCounterWidth'(1)));
  assign w_unused_wdata = ^wdata_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_OFF;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_load        = 1'b0;
    w_set_err     = 1'b0;
    w_clr_en      = 1'b0;
    w_pending_nxt = r_pending;
    case (r_state)
      ST_OFF: begin
        w_pending_nxt = 1'b0;
        if (w_commit_wr) w_load = 1'b1;
        if (w_en_wr) begin
          if (w_sh_ok) begin
            w_state_nxt = ST_LOAD;
          end else begin
            w_set_err = 1'b1;
            w_clr_en  = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        w_load        = 1'b1;
        w_pending_nxt = 1'b0;
        w_state_nxt   = w_en_wr ? ST_RUN : ST_OFF;
      end
      ST_RUN: begin
        if (!w_en_wr) begin
          w_state_nxt   = ST_OFF;
          w_pending_nxt = 1'b0;
          if (w_commit_wr) w_load = 1'b1;
        end else begin
          if (w_boundary && r_pending) begin
            if (w_sh_ok) w_load = 1'b1;
            else         w_set_err = 1'b1;
            w_pending_nxt = 1'b0;
          end
          // A commit landing on a boundary waits for the next one.
          if (w_commit_wr) w_pending_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_OFF;
    endcase
  end

  always_comb begin
    w_rdata = '0;
    case (addr_i)
      AddrCtrl:   w_rdata = 32'({r_div, 6'd0, 1'b0, r_enable});
      AddrHsync:  w_rdata = 32'(r_sh_hsync);
      AddrHstart: w_rdata = 32'(r_sh_hstart);
      AddrHend:   w_rdata = 32'(r_sh_hend);
      AddrHtotal: w_rdata = 32'(r_sh_htotal);
      AddrVsync:  w_rdata = 32'(r_sh_vsync);
      AddrVstart: w_rdata = 32'(r_sh_vstart);
      AddrVend:   w_rdata = 32'(r_sh_vend);
      AddrVtotal: w_rdata = 32'(r_sh_vtotal);
      AddrStatus: w_rdata = {r_frame_cnt, 12'd0, r_cfg_err, r_pending, r_state};
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_enable    <= 1'b0;
      r_div       <= '0;
      r_div_cnt   <= '0;
      r_pending   <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_frame_cnt <= '0;
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
      r_sh_hsync  <= '0; r_sh_hstart <= '0; r_sh_hend <= '0; r_sh_htotal <= '0;
      r_sh_vsync  <= '0; r_sh_vstart <= '0; r_sh_vend <= '0; r_sh_vtotal <= '0;
      r_hsync     <= '0; r_hstart    <= '0; r_hend    <= '0; r_htotal    <= '0;
      r_vsync     <= '0; r_vstart    <= '0; r_vend    <= '0; r_vtotal    <= '0;
    end else begin
      r_rvalid <= req_i;
      r_rdata  <= (req_i && !we_i) ? w_rdata : '0;
      if (w_wr) begin
        case (addr_i)
          AddrCtrl: begin
            r_enable <= wdata_i[0];
            r_div    <= wdata_i[8 +: ClkDivWidth];
          end
          AddrHsync:  r_sh_hsync  <= wdata_i[HCounterWidth-1:0];
          AddrHstart: r_sh_hstart <= wdata_i[HCounterWidth-1:0];
          AddrHend:   r_sh_hend   <= wdata_i[HCounterWidth-1:0];
          AddrHtotal: r_sh_htotal <= wdata_i[HCounterWidth-1:0];
          AddrVsync:  r_sh_vsync  <= wdata_i[VCounterWidth-1:0];
          AddrVstart: r_sh_vstart <= wdata_i[VCounterWidth-1:0];
          AddrVend:   r_sh_vend   <= wdata_i[VCounterWidth-1:0];
          AddrVtotal: r_sh_vtotal <= wdata_i[VCounterWidth-1:0];
          AddrStatus: if (wdata_i[3]) r_cfg_err <= 1'b0;
          default: ;
        endcase
      end
      if (w_clr_en)  r_enable  <= 1'b0;
      if (w_set_err) r_cfg_err <= 1'b1;
      if (w_load) begin
        r_hsync <= r_sh_hsync; r_hstart <= r_sh_hstart; r_hend <= r_sh_hend; r_htotal <= r_sh_htotal;
        r_vsync <= r_sh_vsync; r_vstart <= r_sh_vstart; r_vend <= r_sh_vend; r_vtotal <= r_sh_vtotal;
      end
      r_pending <= w_pending_nxt;
      if (w_boundary) r_frame_cnt <= r_frame_cnt + 16'd1;
      // Divider free-runs only in RUN so the first tick lands div cycles after entry.
      if ((r_state == ST_RUN) && (r_div_cnt < r_div)) r_div_cnt <= r_div_cnt + ClkDivWidth'(1);
      else                                             r_div_cnt <= '0;
    end
  end

  assign rvalid_o      = r_rvalid;
  assign rdata_o       = r_rdata;
  assign driver_rst_o  = (r_state != ST_RUN);
  assign driver_en_o   = (r_state == ST_RUN) ? w_tick : 1'b1;
  assign frame_start_o = w_boundary;
  assign hsync_o  = r_hsync;  assign hstart_o = r_hstart;
  assign hend_o   = r_hend;   assign htotal_o = r_htotal;
  assign vsync_o  = r_vsync;  assign vstart_o = r_vstart;
  assign vend_o   = r_vend;   assign vtotal_o = r_vtotal;

endmodule

// File: tb/tb_display_timing_ctrl.sv
// Self-checking bench for display_timing_ctrl: register table, directed frame-commit
// sequences and a randomized run against a behavioural controller model.
module tb_display_timing_ctrl;

  logic        clk = 1'b0;
  logic        rst_i, req_i, we_i;
  logic [3:0]  addr_i;
  logic [31:0] wdata_i, rdata_o;
  logic        rvalid_o, driver_en_o, driver_rst_o, frame_start_o;
  logic [11:0] hcounter_i, vcounter_i;
  logic [11:0] hsync_o, hstart_o, hend_o, htotal_o, vsync_o, vstart_o, vend_o, vtotal_o;

  int   checks = 0;
  int   errors = 0;
  logic c_fs, c_en, c_rst;

  always #5 clk = ~clk;

  display_timing_ctrl #(.HCounterWidth(12), .VCounterWidth(12), .ClkDivWidth(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .hcounter_i(hcounter_i), .vcounter_i(vcounter_i),
    .driver_en_o(driver_en_o), .driver_rst_o(driver_rst_o),
    .hsync_o(hsync_o), .hstart_o(hstart_o), .hend_o(hend_o), .htotal_o(htotal_o),
    .vsync_o(vsync_o), .vstart_o(vstart_o), .vend_o(vend_o), .vtotal_o(vtotal_o),
    .frame_start_o(frame_start_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle: inputs set just after an edge, combinational outputs captured, then clocked.
  task automatic step(input logic rq, input logic w, input logic [3:0] a, input logic [31:0] d,
                      input logic [11:0] h, input logic [11:0] v);
    req_i = rq; we_i = w; addr_i = a; wdata_i = d; hcounter_i = h; vcounter_i = v;
    #1;
    c_fs = frame_start_o; c_en = driver_en_o; c_rst = driver_rst_o;
    @(posedge clk);
    #1;
    req_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, a, d, 12'd0, 12'd0);
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
    step(1'b1, 1'b0, a, 32'd0, 12'd0, 12'd0);
    chk({name, "_rvalid"}, 64'(rvalid_o), 64'd1);
    chk(name, 64'(rdata_o), 64'(exp));
  endtask

  task automatic do_reset();
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    hcounter_i = '0; vcounter_i = '0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
  endtask

  // Frame boundary search with a bounded cycle budget; returns whether frame_start was seen.
  task automatic run_to_boundary(input logic [11:0] h, input logic [11:0] v,
                                 input logic [11:0] ht_before, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      chk("htotal_before_boundary", 64'(htotal_o), 64'(ht_before));
      step(1'b0, 1'b0, 4'h0, 32'd0, h, v);
      if (c_fs) seen = 1'b1;
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int          m_sh[16], m_act[16];
  int          m_en, m_div, m_state, m_pend, m_err, m_fcnt, m_runcyc;
  logic        e_fs, e_en, e_rst;
  logic [31:0] e_rdata;

  function automatic int model_read(input int a);
    if (a == 0) return (m_div << 8) | m_en;
    if (a >= 1 && a <= 8) return m_sh[a];
    if (a == 9) return (m_fcnt << 16) | (m_err << 3) | (m_pend << 2) | m_state;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin m_sh[i] = 0; m_act[i] = 0; end
    m_en = 0; m_div = 0; m_state = 0; m_pend = 0; m_err = 0; m_fcnt = 0; m_runcyc = 0;
  endtask

  task automatic model_step(input bit rq, input bit w, input int a, input int d,
                            input int h, input int v);
    int old_sh[16];
    bit run, tick, bnd, wr_op, ctrl, commit, en_req, ok;
    int n_state, n_en, n_err, n_pend;
    old_sh  = m_sh;
    run     = (m_state == 2);
    tick    = run && ((m_runcyc % (m_div + 1)) == m_div);
    bnd     = tick && (h == (m_act[4] + 4095) % 4096) && (v == (m_act[8] + 4095) % 4096);
    e_fs    = bnd;
    e_en    = run ? tick : 1'b1;
    e_rst   = !run;
    e_rdata = (rq && !w) ? 32'(model_read(a)) : 32'h0;
    wr_op   = rq && w;
    ctrl    = wr_op && (a == 0);
    commit  = ctrl && (((d >> 1) & 1) != 0);
    en_req  = ctrl ? ((d & 1) != 0) : (m_en != 0);
    ok      = (m_sh[4] != 0) && (m_sh[8] != 0);
    n_state = m_state; n_err = m_err; n_pend = m_pend;
    n_en    = ctrl ? (d & 1) : m_en;
    if (ctrl) m_div = (d >> 8) & 15;
    if (wr_op && a == 9 && ((d >> 3) & 1) != 0) n_err = 0;
    if (wr_op && a >= 1 && a <= 8) m_sh[a] = d & 32'hFFF;
    if (bnd) m_fcnt = (m_fcnt + 1) % 65536;
    case (m_state)
      0: begin
        n_pend = 0;
        if (commit) m_act = old_sh;
        if (en_req) begin
          if (ok) n_state = 1;
          else begin n_err = 1; n_en = 0; end
        end
      end
      1: begin
        m_act = old_sh; n_pend = 0; n_state = en_req ? 2 : 0;
      end
      default: begin
        if (!en_req) begin
          n_state = 0; n_pend = 0;
          if (commit) m_act = old_sh;
        end else begin
          if (bnd && m_pend != 0) begin
            if (ok) m_act = old_sh; else n_err = 1;
            n_pend = 0;
          end
          if (commit) n_pend = 1;
        end
      end
    endcase
    m_runcyc = (m_state == 2 && n_state == 2) ? m_runcyc + 1 : 0;
    m_state = n_state; m_en = n_en; m_err = n_err; m_pend = n_pend;
  endtask

  // ---------------- register table ----------------
  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [11:0] exp_htotal;
  } vec_t;

  vec_t vecs[20];

  initial begin
    bit seen;
    bit done;

    vecs[0]  = '{1'b0, 4'h0, 32'h0,         32'h0,     12'h0};
    vecs[1]  = '{1'b0, 4'h9, 32'h0,         32'h0,     12'h0};
    vecs[2]  = '{1'b1, 4'h1, 32'hABCD_E060, 32'h0,     12'h0};
    vecs[3]  = '{1'b0, 4'h1, 32'h0,         32'h060,   12'h0};
    vecs[4]  = '{1'b1, 4'h4, 32'h320,       32'h0,     12'h0};
    vecs[5]  = '{1'b0, 4'h4, 32'h0,         32'h320,   12'h0};
    vecs[6]  = '{1'b1, 4'h5, 32'hFFFF_F123, 32'h0,     12'h0};
    vecs[7]  = '{1'b0, 4'h5, 32'h0,         32'h123,   12'h0};
    vecs[8]  = '{1'b1, 4'h8, 32'h0,         32'h0,     12'h0};
    vecs[9]  = '{1'b1, 4'h0, 32'h301,       32'h0,     12'h0};
    vecs[10] = '{1'b0, 4'h0, 32'h0,         32'h300,   12'h0};
    vecs[11] = '{1'b0, 4'h9, 32'h0,         32'h8,     12'h0};
    vecs[12] = '{1'b1, 4'h9, 32'h8,         32'h0,     12'h0};
    vecs[13] = '{1'b0, 4'h9, 32'h0,         32'h0,     12'h0};
    vecs[14] = '{1'b0, 4'hA, 32'h0,         32'h0,     12'h0};
    vecs[15] = '{1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0,     12'h0};
    vecs[16] = '{1'b0, 4'hF, 32'h0,         32'h0,     12'h0};
    vecs[17] = '{1'b1, 4'h0, 32'h2,         32'h0,     12'h320};
    vecs[18] = '{1'b0, 4'h9, 32'h0,         32'h0,     12'h320};
    vecs[19] = '{1'b0, 4'h0, 32'h0,         32'h0,     12'h320};

    do_reset();
    chk("reset_driver_rst", 64'(driver_rst_o), 64'd1);
    chk("reset_driver_en", 64'(driver_en_o), 64'd1);
    chk("reset_rvalid", 64'(rvalid_o), 64'd0);
    chk("reset_rdata", 64'(rdata_o), 64'd0);
    chk("reset_frame_start", 64'(frame_start_o), 64'd0);
    chk("reset_timing", {hsync_o, hstart_o, hend_o, htotal_o}, 64'd0);

    // Bus table, includes enable-with-zero-vtotal error and commit while OFF.
    foreach (vecs[i]) begin
      step(1'b1, vecs[i].we, vecs[i].addr, vecs[i].wdata, 12'd0, 12'd0);
      chk($sformatf("tbl%0d_rvalid", i), 64'(rvalid_o), 64'd1);
      chk($sformatf("tbl%0d_rdata", i), 64'(rdata_o), 64'(vecs[i].exp_rdata));
      chk($sformatf("tbl%0d_htotal", i), 64'(htotal_o), 64'(vecs[i].exp_htotal));
    end

    // Bring-up: LOAD for one cycle, then RUN with tick every other cycle.
    do_reset();
    wr(4'h1, 32'd96);  wr(4'h2, 32'd144); wr(4'h3, 32'd784); wr(4'h4, 32'd800);
    wr(4'h5, 32'd2);   wr(4'h6, 32'd35);  wr(4'h7, 32'd515); wr(4'h8, 32'd525);
    wr(4'h0, 32'h101);
    chk("t1_load_rst", 64'(driver_rst_o), 64'd1);
    chk("t1_load_en", 64'(driver_en_o), 64'd1);
    chk("t1_load_htotal", 64'(htotal_o), 64'd0);
    step(1'b0, 1'b0, 4'h0, 32'd0, 12'd0, 12'd0);
    chk("t1_run_rst", 64'(driver_rst_o), 64'd0);
    chk("t1_h_timing", {16'd0, hsync_o, hstart_o, hend_o, htotal_o},
        {16'd0, 12'd96, 12'd144, 12'd784, 12'd800});
    chk("t1_v_timing", {16'd0, vsync_o, vstart_o, vend_o, vtotal_o},
        {16'd0, 12'd2, 12'd35, 12'd515, 12'd525});
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 4'h0, 32'd0, 12'd0, 12'd0);
      chk($sformatf("t1_en_cycle%0d", k), 64'(c_en), 64'(k % 2));
    end
    rd_chk("t1_status", 4'h9, 32'h2);

    // Mid-frame commit waits for the frame boundary.
    wr(4'h4, 32'd900);
    wr(4'h0, 32'h103);
    rd_chk("t2_status_pending", 4'h9, 32'h6);
    run_to_boundary(12'd799, 12'd524, 12'd800, seen);
    chk("t2_boundary_seen", 64'(seen), 64'd1);
    chk("t2_htotal_new", 64'(htotal_o), 64'd900);
    rd_chk("t2_status_after", 4'h9, 32'h0001_0002);

    // Commit issued on the boundary cycle itself applies one frame later.
    wr(4'h4, 32'd1000);
    done = 1'b0;
    for (int k = 0; k < 8 && !done; k++) begin
      req_i = 1'b0; hcounter_i = 12'd899; vcounter_i = 12'd524;
      #1;
      if (frame_start_o) begin
        req_i = 1'b1; we_i = 1'b1; addr_i = 4'h0; wdata_i = 32'h103; done = 1'b1;
      end
      @(posedge clk);
      #1;
      req_i = 1'b0; we_i = 1'b0;
    end
    chk("t4_boundary_seen", 64'(done), 64'd1);
    chk("t4_htotal_held", 64'(htotal_o), 64'd900);
    rd_chk("t4_status_pending", 4'h9, 32'h0002_0006);
    run_to_boundary(12'd899, 12'd524, 12'd900, seen);
    chk("t4_boundary2_seen", 64'(seen), 64'd1);
    chk("t4_htotal_new", 64'(htotal_o), 64'd1000);
    rd_chk("t4_status_after", 4'h9, 32'h0003_0002);

    // Disable with a commit pending: driver reset at once, pending dropped.
    wr(4'h4, 32'd1100);
    wr(4'h0, 32'h103);
    wr(4'h0, 32'h100);
    chk("t5_driver_rst", 64'(driver_rst_o), 64'd1);
    chk("t5_driver_en", 64'(driver_en_o), 64'd1);
    chk("t5_htotal_kept", 64'(htotal_o), 64'd1000);
    rd_chk("t5_status", 4'h9, 32'h0003_0000);

    // Asynchronous reset while running.
    wr(4'h0, 32'h101);
    repeat (3) step(1'b0, 1'b0, 4'h0, 32'd0, 12'd0, 12'd0);
    chk("t6_running", 64'(driver_rst_o), 64'd0);
    step(1'b1, 1'b0, 4'h9, 32'd0, 12'd1099, 12'd524);
    chk("t6_pre_rvalid", 64'(rvalid_o), 64'd1);
    #2 rst_i = 1'b1;
    #1;
    chk("t6_rvalid", 64'(rvalid_o), 64'd0);
    chk("t6_rdata", 64'(rdata_o), 64'd0);
    chk("t6_driver_rst", 64'(driver_rst_o), 64'd1);
    chk("t6_driver_en", 64'(driver_en_o), 64'd1);
    chk("t6_frame_start", 64'(frame_start_o), 64'd0);
    chk("t6_timing", {vtotal_o, htotal_o, hsync_o}, 64'd0);
    @(posedge clk);
    #1 rst_i = 1'b0;
    rd_chk("t6_unmapped", 4'hA, 32'h0);
    rd_chk("t6_status", 4'h9, 32'h0);

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    begin
      int divfix;
      divfix = $urandom_range(0, 2);
      for (int n = 0; n < 3000; n++) begin
        int r, a, d, h, v;
        bit rq, w;
        r = $urandom_range(0, 99);
        rq = 1'b1; w = 1'b1; a = 0; d = 0;
        if (r < 35) begin
          rq = 1'b0; w = 1'b0;
        end else if (r < 60) begin
          a = $urandom_range(1, 8);
          if (a == 4 || a == 8) d = int'($urandom & 32'hFFFF_F000) | $urandom_range(0, 6);
          else                  d = int'($urandom);
        end else if (r < 70) begin
          d = (divfix << 8) | 3;
        end else if (r < 73) begin
          d = (divfix << 8) | 1;
        end else if (r < 75) begin
          d = (divfix << 8) | ($urandom_range(0, 1) << 1);
        end else if (r < 77) begin
          a = 9; d = int'($urandom);
        end else begin
          w = 1'b0; a = $urandom_range(0, 15);
        end
        if ($urandom_range(0, 1) == 1) begin
          h = (m_act[4] + 4095) % 4096; v = (m_act[8] + 4095) % 4096;
        end else begin
          h = $urandom_range(0, 7); v = $urandom_range(0, 7);
        end
        model_step(rq, w, a, d, h, v);
        step(rq, w, 4'(a), 32'(d), 12'(h), 12'(v));
        chk($sformatf("rnd%0d_frame_start", n), 64'(c_fs), 64'(e_fs));
        chk($sformatf("rnd%0d_driver_en", n), 64'(c_en), 64'(e_en));
        chk($sformatf("rnd%0d_driver_rst", n), 64'(c_rst), 64'(e_rst));
        chk($sformatf("rnd%0d_rvalid", n), 64'(rvalid_o), 64'(rq));
        chk($sformatf("rnd%0d_rdata", n), 64'(rdata_o), 64'(e_rdata));
        chk($sformatf("rnd%0d_h_active", n), {16'd0, hsync_o, hstart_o, hend_o, htotal_o},
            {16'd0, 12'(m_act[1]), 12'(m_act[2]), 12'(m_act[3]), 12'(m_act[4])});
        chk($sformatf("rnd%0d_v_active", n), {16'd0, vsync_o, vstart_o, vend_o, vtotal_o},
            {16'd0, 12'(m_act[5]), 12'(m_act[6]), 12'(m_act[7]), 12'(m_act[8])});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
